// File: rtl/neuron_output_stage.sv
// Neuron output stage: accumulates N_PARTS sign-magnitude MAC partial sums plus bias,
// then rescales, clips and optionally rectifies the result into an 8-bit activation.
module neuron_output_stage #(
  parameter int unsigned N_PARTS = 4,
  parameter int unsigned SHIFT   = 7,
  parameter int unsigned RELU    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mac_valid,
  output logic        mac_ready,
  input  logic [20:0] mac_data,
  input  logic [7:0]  bias,
  output logic        act_valid,
  input  logic        act_ready,
  output logic [7:0]  act_data,
  output logic        act_sat,
  output logic [7:0]  neuron_idx
);

  localparam int unsigned ACC_W = 26;
  localparam int unsigned CNT_W = (N_PARTS > 1) ? $clog2(N_PARTS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_PARTS - 1);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_valid_q, act_valid_d;
  logic [7:0]       act_data_q, act_data_d;
  logic             act_sat_q, act_sat_d;
  logic [7:0]       idx_q, idx_d;

  logic [ACC_W-1:0] beat_mag, beat_term;
  logic [ACC_W-1:0] bias_mag, bias_term;
  logic             acc_neg;
  logic [ACC_W-1:0] acc_abs, mag_sh;
  logic [6:0]       res_mag;
  logic             res_sat;
  logic [7:0]       res_data;

  assign mac_ready  = (state_q == ACCUM) && !rst;
  assign act_valid  = act_valid_q;
  assign act_data   = act_data_q;
  assign act_sat    = act_sat_q;
  assign neuron_idx = idx_q;

  // Sign-magnitude operands mapped onto the two's complement accumulator.
  always_comb begin
    beat_mag  = ACC_W'(mac_data[19:0]);
    beat_term = mac_data[20] ? (ACC_W'(0) - beat_mag) : beat_mag;
    bias_mag  = ACC_W'(bias[6:0]) << SHIFT;
    bias_term = bias[7] ? (ACC_W'(0) - bias_mag) : bias_mag;
  end

  // Rescale, clip and rectify the finished sum; zero magnitude never carries a sign.
  always_comb begin
    acc_neg  = acc_q[ACC_W-1];
    acc_abs  = acc_neg ? (ACC_W'(0) - acc_q) : acc_q;
    mag_sh   = acc_abs >> SHIFT;
    res_sat  = 1'b0;
    res_mag  = mag_sh[6:0];
    if (mag_sh > ACC_W'(127)) begin
      res_mag = 7'd127;
      res_sat = 1'b1;
    end
    res_data = {acc_neg, res_mag};
    if ((RELU != 0) && acc_neg) begin
      res_data = 8'h00;
      res_sat  = 1'b0;
    end else if (res_mag == 7'd0) begin
      res_data = 8'h00;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    act_valid_d = act_valid_q;
    act_data_d  = act_data_q;
    act_sat_d   = act_sat_q;
    idx_d       = idx_q;
    case (state_q)
      ACCUM: begin
        if (mac_valid) begin
          acc_d = acc_q + beat_term + ((cnt_q == '0) ? bias_term : ACC_W'(0));
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FINISH: begin
        act_data_d  = res_data;
        act_sat_d   = res_sat;
        act_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (act_ready) begin
          act_valid_d = 1'b0;
          idx_d       = idx_q + 8'd1;
          acc_d       = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      act_valid_q <= 1'b0;
      act_data_q  <= 8'h00;
      act_sat_q   <= 1'b0;
      idx_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      act_valid_q <= act_valid_d;
      act_data_q  <= act_data_d;
      act_sat_q   <= act_sat_d;
      idx_q       <= idx_d;
    end
  end

endmodule
